// File: rtl/pll_reset_seq.sv
// Reset sequencer behind the PLL: syncs `locked`, waits for stable lock, then releases reset domains in order.
// Latency: rst_out_n[i] releases 2+LOCK_STABLE_CYCLES+i*STAGE_GAP edges after `locked` rises; loss re-asserts within 3 edges.
// Backpressure: none, all outputs are registered levels. PLL_RESET_SEQ_WATCHDOG_EN builds the lock-timeout PLL reset pulse.
module pll_reset_seq #(
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int STAGES             = 3,
    parameter int STAGE_GAP          = 8,
    parameter int WATCHDOG_CYCLES    = 65536
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              locked,
    output logic [STAGES-1:0] rst_out_n,
    output logic              ready,
    output logic [7:0]        loss_count,
    output logic              pll_rst
);

    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_STABLE_CYCLES);
    localparam logic [GW-1:0] GAP_MAX  = GW'(STAGE_GAP);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

    if (LOCK_STABLE_CYCLES < 1 || STAGES < 1 || STAGES > 8 || STAGE_GAP < 1 || WATCHDOG_CYCLES < 1) begin : g_bad_param
        $error("pll_reset_seq: illegal parameter value");
    end

    state_t            state, state_nxt;
    logic              sync1, locked_s;
    logic [SW-1:0]     stab, stab_nxt;
    logic [GW-1:0]     gap, gap_nxt;
    logic [STAGES-1:0] rst_nxt;
    logic              ready_nxt;
    logic [7:0]        loss_nxt;
    logic              rel_entry;
    logic              wd_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= locked;
            locked_s <= sync1;
        end
    end

    // Stability window completes on this edge; shared with the watchdog so it can clear on the same edge.
    assign rel_entry = locked_s &&
                       ((state == WAIT_LOCK && STAB_MAX == SW'(1)) ||
                        (state == STABLE && (stab + SW'(1)) == STAB_MAX));

    always_comb begin
        state_nxt = state;
        stab_nxt  = stab;
        gap_nxt   = gap;
        rst_nxt   = rst_out_n;
        ready_nxt = ready;
        loss_nxt  = loss_count;
        unique case (state)
            WAIT_LOCK: begin
                rst_nxt   = '0;
                ready_nxt = 1'b0;
                stab_nxt  = '0;
                if (locked_s) begin
                    stab_nxt  = SW'(1);
                    state_nxt = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    stab_nxt  = '0;
                end else begin
                    stab_nxt = stab + SW'(1);
                end
            end
            RELEASE, RUN: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    stab_nxt  = '0;
                    rst_nxt   = '0;
                    ready_nxt = 1'b0;
                    if (loss_count != 8'hff) loss_nxt = loss_count + 8'd1;
                end else if (state == RELEASE) begin
                    gap_nxt = gap + GW'(1);
                    if (gap_nxt == GAP_MAX) begin
                        gap_nxt = '0;
                        // Released stages are a contiguous run from bit 0, so shifting in releases the next one.
                        rst_nxt = rst_out_n | (rst_out_n << 1);
                        if (rst_nxt[STAGES-1]) begin
                            state_nxt = RUN;
                            ready_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase

        if (rel_entry) begin
            stab_nxt = '0;
            gap_nxt  = '0;
            rst_nxt  = STAGES'(1);
            if (STAGES == 1) begin
                state_nxt = RUN;
                ready_nxt = 1'b1;
            end else begin
                state_nxt = RELEASE;
            end
        end

        if (wd_hold) begin
            state_nxt = WAIT_LOCK;
            stab_nxt  = '0;
            rst_nxt   = '0;
            ready_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_LOCK;
            stab       <= '0;
            gap        <= '0;
            rst_out_n  <= '0;
            ready      <= 1'b0;
            loss_count <= '0;
        end else begin
            state      <= state_nxt;
            stab       <= stab_nxt;
            gap        <= gap_nxt;
            rst_out_n  <= rst_nxt;
            ready      <= ready_nxt;
            loss_count <= loss_nxt;
        end
    end

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    localparam int TW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [TW-1:0] WD_MAX = TW'(WATCHDOG_CYCLES);

    logic [TW-1:0] wd_timer, wd_timer_nxt;
    logic [4:0]    pulse, pulse_nxt;
    logic          wd_fire;

    // The FSM is held in WAIT_LOCK for the whole pulse, so a release can never overlap pll_rst.
    always_comb begin
        wd_fire      = 1'b0;
        wd_timer_nxt = '0;
        if ((state == WAIT_LOCK || state == STABLE) && !(rel_entry && pulse == 5'd0)) begin
            wd_timer_nxt = wd_timer + TW'(1);
            if (wd_timer_nxt == WD_MAX) begin
                wd_fire      = 1'b1;
                wd_timer_nxt = '0;
            end
        end
        if (wd_fire)              pulse_nxt = 5'd16;
        else if (pulse != 5'd0)   pulse_nxt = pulse - 5'd1;
        else                      pulse_nxt = 5'd0;
        wd_hold = wd_fire || (pulse != 5'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_timer <= '0;
            pulse    <= '0;
            pll_rst  <= 1'b0;
        end else begin
            wd_timer <= wd_timer_nxt;
            pulse    <= pulse_nxt;
            pll_rst  <= (pulse_nxt != 5'd0);
        end
    end
`else
    assign wd_hold = 1'b0;
    assign pll_rst = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: vector table for the clean-lock timeline, hand sequences for loss/reset corners,
// and random lock/unlock runs checked against a lock-streak reference model.
module tb_pll_reset_seq;

    localparam int L = 8;
    localparam int S = 3;
    localparam int G = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         locked = 1'b0;
    logic [S-1:0] rst_out_n;
    logic         ready;
    logic [7:0]   loss_count;
    logic         pll_rst;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: two-sample delay line, then a count of consecutive synchronised-high samples.
    logic m_s1, m_s2;
    int   streak;
    int   m_loss;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .LOCK_STABLE_CYCLES(L), .STAGES(S), .STAGE_GAP(G), .WATCHDOG_CYCLES(65536)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .locked(locked),
        .rst_out_n(rst_out_n), .ready(ready), .loss_count(loss_count), .pll_rst(pll_rst)
    );

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    logic         wd_locked = 1'b0;
    logic [S-1:0] wd_rst;
    logic         wd_ready;
    logic [7:0]   wd_loss;
    logic         wd_pll_rst;

    pll_reset_seq #(
        .LOCK_STABLE_CYCLES(L), .STAGES(S), .STAGE_GAP(G), .WATCHDOG_CYCLES(50)
    ) u_wd (
        .clk(clk), .reset_n(reset_n), .locked(wd_locked),
        .rst_out_n(wd_rst), .ready(wd_ready), .loss_count(wd_loss), .pll_rst(wd_pll_rst)
    );
`endif

    typedef struct {
        int         at_edge;
        logic [2:0] rst;
        logic       rdy;
    } vec_t;

    function automatic int exp_stages();
        int n;
        if (streak < L) return 0;
        n = 1 + (streak - L) / G;
        return (n > S) ? S : n;
    endfunction

    task automatic model_clear();
        m_s1   = 1'b0;
        m_s2   = 1'b0;
        streak = 0;
        m_loss = 0;
    endtask

    task automatic model_edge();
        logic ls;
        if (!reset_n) begin
            model_clear();
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = locked;
        if (ls) begin
            if (streak < 100000) streak++;
        end else begin
            if (streak >= L && m_loss < 255) m_loss++;
            streak = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic step();
        int n;
        @(posedge clk);
        model_edge();
        edge_n++;
        #1;
        n = exp_stages();
        check("rst_out_n", 32'(rst_out_n), 32'((1 << n) - 1));
        check("ready", 32'(ready), 32'(n == S));
        check("loss_count", 32'(loss_count), 32'(m_loss));
        check("pll_rst", 32'(pll_rst), 32'd0);
    endtask

    // Called 1 time unit after a rising edge; asserts reset mid-cycle and releases it mid-cycle.
    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        locked  = 1'b0;
        model_clear();
        #1;
        check("async_rst_out_n", 32'(rst_out_n), 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        check("async_loss", 32'(loss_count), 32'd0);
        check("async_pll_rst", 32'(pll_rst), 32'd0);
        step();
        #3;
        reset_n = 1'b1;
        edge_n  = 0;
    endtask

    initial begin
        vec_t vt[8];
        vt[0] = '{9,  3'b000, 1'b0};
        vt[1] = '{18, 3'b000, 1'b0};
        vt[2] = '{19, 3'b001, 1'b0};
        vt[3] = '{22, 3'b001, 1'b0};
        vt[4] = '{23, 3'b011, 1'b0};
        vt[5] = '{26, 3'b011, 1'b0};
        vt[6] = '{27, 3'b111, 1'b1};
        vt[7] = '{35, 3'b111, 1'b1};

        model_clear();
        do_reset();

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        // Lock never arrives on the second instance: 16-cycle pulse every 50 cycles.
        for (int i = 0; i < 160; i++) begin
            step();
            check("wd_pll_rst", 32'(wd_pll_rst), 32'(edge_n >= 50 && ((edge_n - 50) % 50) < 16));
        end
        do_reset();
`endif

        // Clean lock: `locked` first sampled at edge 10.
        for (int i = 0; i < 8; i++) begin
            while (edge_n < vt[i].at_edge) begin
                step();
                if (edge_n == 9) locked = 1'b1;
            end
            check("vec_rst_out_n", 32'(rst_out_n), 32'(vt[i].rst));
            check("vec_ready", 32'(ready), 32'(vt[i].rdy));
        end

        // Loss in RUN, then relock repeats the sequence.
        locked = 1'b0;
        repeat (3) step();
        check("run_loss_rst", 32'(rst_out_n), 32'd0);
        check("run_loss_ready", 32'(ready), 32'd0);
        check("run_loss_count", 32'(loss_count), 32'd1);
        locked = 1'b1;
        repeat (30) step();
        check("relock_rst", 32'(rst_out_n), 32'h7);
        check("relock_ready", 32'(ready), 32'd1);

        // Loss in RELEASE at 011.
        do_reset();
        locked = 1'b1;
        repeat (14) step();
        check("rel_mid_rst", 32'(rst_out_n), 32'h3);
        locked = 1'b0;
        repeat (3) step();
        check("rel_loss_rst", 32'(rst_out_n), 32'd0);
        check("rel_loss_count", 32'(loss_count), 32'd1);

        // Async reset mid-RELEASE clears a non-zero loss count.
        locked = 1'b1;
        repeat (14) step();
        check("pre_arst_rst", 32'(rst_out_n), 32'h3);
        check("pre_arst_loss", 32'(loss_count), 32'd1);
        do_reset();

        // Unstable lock: 5 high, 2 low, then high.
        locked = 1'b1;
        repeat (5) step();
        locked = 1'b0;
        repeat (2) step();
        locked = 1'b1;
        repeat (9) step();
        check("unstable_hold", 32'(rst_out_n), 32'd0);
        step();
        check("unstable_release", 32'(rst_out_n), 32'h1);
        check("unstable_loss", 32'(loss_count), 32'd0);

        // Loss counter saturation.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            locked = 1'b1;
            repeat (12) step();
            locked = 1'b0;
            repeat (4) step();
        end
        check("loss_saturate", 32'(loss_count), 32'd255);

        // Random lock/unlock runs.
        do_reset();
        for (int i = 0; i < 120; i++) begin
            locked = 1'b1;
            repeat ($urandom_range(1, 30)) step();
            locked = 1'b0;
            repeat ($urandom_range(1, 5)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
